// File: rtl/wavelet_pkg.sv
// Shared wavelet constants: default widths, sym4 filter taps in Q2.23, synthesis FSM states.
package wavelet_pkg;

  localparam int unsigned INTERNAL_WIDTH_DEF = 48;
  localparam int unsigned COEF_WIDTH_DEF     = 25;
  localparam int unsigned COEF_FRAC_DEF      = 23;
  localparam int unsigned MULT_WIDTH_DEF     = INTERNAL_WIDTH_DEF + COEF_WIDTH_DEF;

  // sym4 reconstruction low-pass taps h0..h7, Q2.23
  localparam int SYM4_REC [8] = '{
    270307, -105730, -832314, 2498612, 6742249, 4174328, -248601, -635569
  };

  // Decomposition low-pass is the time-reversed reconstruction filter
  function automatic int sym4_dec(input int unsigned idx);
    return SYM4_REC[7 - (idx % 8)];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE_E = 2'd1,
    ST_GAP     = 2'd2,
    ST_ISSUE_O = 2'd3
  } recon_state_e;

endpackage

// File: rtl/recon_mac4.sv
// Four-lane registered multiply (S1) followed by a registered adder tree (S2).
module recon_mac4 import wavelet_pkg::*; #(
  parameter int unsigned IW = INTERNAL_WIDTH_DEF,
  parameter int unsigned CW = COEF_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 phase_i,
  input  logic [3:0][IW-1:0]   x_i,
  input  logic [3:0][CW-1:0]   c_i,
  output logic                 valid_o,
  output logic                 phase_o,
  output logic [IW+CW+1:0]     sum_o
);

  localparam int unsigned MW = IW + CW;
  localparam int unsigned SW = MW + 2;

  logic [3:0][MW-1:0] prod_q;
  logic               s1_valid_q, s1_phase_q;
  logic [SW-1:0]      sum_c, sum_q;
  logic               s2_valid_q, s2_phase_q;

  // S1: full-precision signed products, both operands extended to MW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_phase_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      if (valid_i) begin
        s1_phase_q <= phase_i;
        for (int k = 0; k < 4; k++) begin
          prod_q[k] <= $signed({{CW{x_i[k][IW-1]}}, x_i[k]}) *
                       $signed({{IW{c_i[k][CW-1]}}, c_i[k]});
        end
      end
    end
  end

  // Adder tree with two guard bits so four products never overflow
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < 4; k++) begin
      sum_c = sum_c + {{2{prod_q[k][MW-1]}}, prod_q[k]};
    end
  end

  // S2: register the tap sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_phase_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q      <= sum_c;
        s2_phase_q <= s1_phase_q;
      end
    end
  end

  assign valid_o = s2_valid_q;
  assign phase_o = s2_phase_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/reconstruct_l6.sv
// Level-6 approximation synthesis: upsample-by-2 + sym4 low-pass in polyphase form,
// four shared multipliers alternate between even and odd output phases.
// Build option RECON_L6_SATURATE_EN: clamp the output slice instead of wrapping.
module reconstruct_l6 import wavelet_pkg::*; #(
  parameter int unsigned INTERNAL_WIDTH = INTERNAL_WIDTH_DEF,
  parameter int unsigned COEF_WIDTH     = COEF_WIDTH_DEF,
  parameter int unsigned COEF_FRAC      = COEF_FRAC_DEF,
  parameter int          REC_H0         = 0,
  parameter int          REC_H1         = 0,
  parameter int          REC_H2         = 0,
  parameter int          REC_H3         = 0,
  parameter int          REC_H4         = 0,
  parameter int          REC_H5         = 0,
  parameter int          REC_H6         = 0,
  parameter int          REC_H7         = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din_valid,
  input  logic [INTERNAL_WIDTH-1:0] a6_in,
  output logic                      dout_valid,
  output logic [INTERNAL_WIDTH-1:0] ra5_out,
  output logic                      dout_phase,
  output logic                      overrun
);

  localparam int unsigned IW = INTERNAL_WIDTH;
  localparam int unsigned CW = COEF_WIDTH;
  localparam int unsigned SW = IW + CW + 2;

  // Tap sets per phase; lane k multiplies hist[k] = x[n-k]
  localparam logic [3:0][CW-1:0] TAPS_E = {CW'(REC_H6), CW'(REC_H4), CW'(REC_H2), CW'(REC_H0)};
  localparam logic [3:0][CW-1:0] TAPS_O = {CW'(REC_H7), CW'(REC_H5), CW'(REC_H3), CW'(REC_H1)};

  recon_state_e       state_q, state_d;
  logic               issue_c, odd_c, ovr_hit_c;
  logic [3:0][IW-1:0] hist_q;
  logic [1:0]         fill_q;
  logic               warm_q;
  logic [3:0][CW-1:0] taps_c;
  logic               mac_valid, mac_phase;
  logic [SW-1:0]      mac_sum;
  logic [IW-1:0]      slice_c;
  logic               mac_sum_unused_c;
  logic               dout_valid_q, dout_phase_q, overrun_q;
  logic [IW-1:0]      ra5_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and issue strobes; a new sample always restarts at the even issue
  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    odd_c     = 1'b0;
    ovr_hit_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (din_valid) state_d = ST_ISSUE_E;
      end
      ST_ISSUE_E: begin
        issue_c   = 1'b1;
        ovr_hit_c = din_valid;
        state_d   = din_valid ? ST_ISSUE_E : ST_GAP;
      end
      ST_GAP: begin
        ovr_hit_c = din_valid;
        state_d   = din_valid ? ST_ISSUE_E : ST_ISSUE_O;
      end
      ST_ISSUE_O: begin
        issue_c = 1'b1;
        odd_c   = 1'b1;
        state_d = din_valid ? ST_ISSUE_E : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // History shift, warm-up tracking and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      warm_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (ovr_hit_c) overrun_q <= 1'b1;
      if (din_valid) begin
        hist_q <= {hist_q[2:0], a6_in};
        warm_q <= (fill_q == 2'd3);
        if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      end
    end
  end

  // Phase tap select into the shared multipliers
  always_comb begin
    taps_c = odd_c ? TAPS_O : TAPS_E;
  end

  recon_mac4 #(
    .IW (IW),
    .CW (CW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (issue_c & warm_q),
    .phase_i (odd_c),
    .x_i     (hist_q),
    .c_i     (taps_c),
    .valid_o (mac_valid),
    .phase_o (mac_phase),
    .sum_o   (mac_sum)
  );

  // S3 floor slice back to Q25.23, optionally clamped on overflow
  always_comb begin
    slice_c = mac_sum[COEF_FRAC+IW-1:COEF_FRAC];
`ifdef RECON_L6_SATURATE_EN
    if (!(&mac_sum[SW-1:COEF_FRAC+IW-1]) && (|mac_sum[SW-1:COEF_FRAC+IW-1])) begin
      slice_c = mac_sum[SW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    end
`endif
  end

  assign mac_sum_unused_c = ^{mac_sum[SW-1:COEF_FRAC+IW], mac_sum[COEF_FRAC-1:0]};

  // S3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid_q <= 1'b0;
      ra5_q        <= '0;
      dout_phase_q <= 1'b0;
    end else begin
      dout_valid_q <= mac_valid;
      if (mac_valid) begin
        ra5_q        <= slice_c;
        dout_phase_q <= mac_phase;
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign ra5_out    = ra5_q;
  assign dout_phase = dout_phase_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_reconstruct_l6.sv
// Bench for reconstruct_l6: two instances (sym4 taps, all-max taps) share one random
// input stream; expected outputs come from direct convolution of the accepted samples.
`timescale 1ns/1ps
module tb_reconstruct_l6;
  import wavelet_pkg::*;

  localparam int unsigned IW   = 48;
  localparam int unsigned CF   = 23;
  localparam int          NCYC = 4096;
  localparam int          HMAX = 8388607;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_valid = 1'b0;
  logic [IW-1:0] a6_in = '0;
  logic          dv_a, ph_a, ov_a, dv_b, ph_b, ov_b;
  logic [IW-1:0] y_a, y_b;

  always #5 clk = ~clk;

  reconstruct_l6 #(
    .REC_H0(SYM4_REC[0]), .REC_H1(SYM4_REC[1]), .REC_H2(SYM4_REC[2]), .REC_H3(SYM4_REC[3]),
    .REC_H4(SYM4_REC[4]), .REC_H5(SYM4_REC[5]), .REC_H6(SYM4_REC[6]), .REC_H7(SYM4_REC[7])
  ) u_dut_sym4 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .a6_in(a6_in),
    .dout_valid(dv_a), .ra5_out(y_a), .dout_phase(ph_a), .overrun(ov_a)
  );

  reconstruct_l6 #(
    .REC_H0(HMAX), .REC_H1(HMAX), .REC_H2(HMAX), .REC_H3(HMAX),
    .REC_H4(HMAX), .REC_H5(HMAX), .REC_H6(HMAX), .REC_H7(HMAX)
  ) u_dut_max (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .a6_in(a6_in),
    .dout_valid(dv_b), .ra5_out(y_b), .dout_phase(ph_b), .overrun(ov_b)
  );

  int            n_checks, n_pass, cyc, last_in;
  bit            exp_ovr;
  logic [IW-1:0] xs[$];
  bit            exp_v [NCYC];
  bit            exp_ph[NCYC];
  logic [IW-1:0] exp_ya[NCYC];
  logic [IW-1:0] exp_yb[NCYC];

  // y[2n+odd] = sum_j h[2j+odd] * x[n-j], floored to Q25.23, wrapped or clamped
  function automatic logic [IW-1:0] ref_out(input int k, input bit odd, input bit big);
    logic signed [79:0] acc, xv, hv, q, hi, lo;
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      xv  = 80'($signed(xs[k-j]));
      hv  = big ? 80'(HMAX) : 80'(SYM4_REC[2*j + int'(odd)]);
      acc = acc + xv * hv;
    end
    q  = acc >>> CF;
    hi = (80'sd1 <<< (IW-1)) - 80'sd1;
    lo = -(80'sd1 <<< (IW-1));
`ifdef RECON_L6_SATURATE_EN
    if (q > hi) q = hi;
    if (q < lo) q = lo;
`else
    if (hi < lo) q = lo;
`endif
    return q[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] rand_x();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if ($urandom_range(0, 3) == 0) return r[IW-1:0];
    return IW'($signed(r[35:0]));
  endfunction

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
  endtask

  task automatic check_outputs();
    chk("overrun_sym4", IW'(ov_a), IW'(exp_ovr));
    chk("overrun_max",  IW'(ov_b), IW'(exp_ovr));
    chk("valid_sym4",   IW'(dv_a), IW'(exp_v[cyc]));
    chk("valid_max",    IW'(dv_b), IW'(exp_v[cyc]));
    if (exp_v[cyc]) begin
      chk("ra5_sym4",   y_a, exp_ya[cyc]);
      chk("phase_sym4", IW'(ph_a), IW'(exp_ph[cyc]));
      chk("ra5_max",    y_b, exp_yb[cyc]);
      chk("phase_max",  IW'(ph_b), IW'(exp_ph[cyc]));
    end
  endtask

  // New sample: a follow-up within 2 clk cancels the previous odd output and flags overrun
  task automatic accept(input logic [IW-1:0] x);
    int k;
    if (cyc + 6 >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
      $fatal(1);
    end
    k = xs.size();
    xs.push_back(x);
    if (last_in >= 0 && cyc - last_in <= 2) begin
      exp_ovr            = 1'b1;
      exp_v[last_in + 6] = 1'b0;
    end
    if (k >= 3) begin
      exp_v[cyc+4] = 1'b1; exp_ph[cyc+4] = 1'b0;
      exp_ya[cyc+4] = ref_out(k, 1'b0, 1'b0); exp_yb[cyc+4] = ref_out(k, 1'b0, 1'b1);
      exp_v[cyc+6] = 1'b1; exp_ph[cyc+6] = 1'b1;
      exp_ya[cyc+6] = ref_out(k, 1'b1, 1'b0); exp_yb[cyc+6] = ref_out(k, 1'b1, 1'b1);
    end
    last_in = cyc;
  endtask

  task automatic step(input bit dv, input logic [IW-1:0] x);
    @(negedge clk);
    cyc++;
    check_outputs();
    din_valid = dv;
    a6_in     = x;
    if (dv) accept(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0);
  endtask

  task automatic send(input logic [IW-1:0] x, input int gap);
    step(1'b1, x);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    a6_in     = '0;
    xs.delete();
    last_in = -100;
    exp_ovr = 1'b0;
    for (int i = 0; i < NCYC; i++) exp_v[i] = 1'b0;
    #1;
    chk("rst_valid_sym4", IW'(dv_a), '0);
    chk("rst_ra5_sym4",   y_a,       '0);
    chk("rst_phase_sym4", IW'(ph_a), '0);
    chk("rst_ovr_sym4",   IW'(ov_a), '0);
    chk("rst_valid_max",  IW'(dv_b), '0);
    chk("rst_ra5_max",    y_b,       '0);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_in = -100; exp_ovr = 1'b0;
    do_reset();
    idle(3);
    // warm-up ramp: nothing emitted until the fourth sample
    for (int i = 1; i <= 4; i++) send(IW'(i) << CF, 4);
    idle(8);
    // unit impulse followed by zeros walks out the tap values
    send(IW'(1) << CF, 4);
    repeat (4) send('0, 4);
    idle(8);
    // well-spaced random traffic
    repeat (40) send(rand_x(), $urandom_range(3, 6));
    idle(8);
    // overrun: 2 clk and 1 clk spacings
    send(rand_x(), 2);
    send(rand_x(), 4);
    send(rand_x(), 1);
    send(rand_x(), 4);
    idle(8);
    // reset one clock after a sample; warm-up must repeat
    step(1'b1, rand_x());
    do_reset();
    idle(8);
    repeat (4) send(rand_x(), 4);
    idle(8);
    // overflow: every tap at max, x = 2^46
    repeat (4) send(IW'(1) << 46, 4);
    idle(8);
    // random traffic including back-to-back and coincident-odd spacings
    repeat (60) send(rand_x(), $urandom_range(1, 6));
    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
